// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for the 32x32 register file: round-robin between
// ALU (req0) and load (req1) writeback, drops writes to r0, and can zero r1..rN-1.
//
// Ports:
//   clock, ctrl_reset (sync, active-low)
//   reqN_valid/reqN_reg/reqN_data in, reqN_ready out (combinational grant)
//   clear_start in (pulse), clear_busy out (registered)
//   rf_writeEn/rf_writeReg/rf_writeData out (registered, to regfile)
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  rf_writeEn,
    output logic [ADDR_WIDTH-1:0] rf_writeReg,
    output logic [DATA_WIDTH-1:0] rf_writeData
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    arb_en;
    logic                    grant0;
    logic                    grant1;

    // State register
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arbitration and datapath outputs.
    // prio_q==0 favours req0; after a grant the loser gets priority.
    always_comb begin
        arb_en  = ctrl_reset && (state_q == S_IDLE) && !clear_start;
        grant0  = arb_en && req0_valid && (!req1_valid || !prio_q);
        grant1  = arb_en && req1_valid && (!req0_valid || prio_q);

        prio_d  = prio_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    idx_d  = IDX_FIRST;
                    busy_d = 1'b1;
                end else if (grant0) begin
                    wreg_d  = req0_reg;
                    wdata_d = req0_data;
                    we_d    = (req0_reg != '0);
                    prio_d  = 1'b1;
                end else if (grant1) begin
                    wreg_d  = req1_reg;
                    wdata_d = req1_data;
                    we_d    = (req1_reg != '0);
                    prio_d  = 1'b0;
                end
            end
            S_CLEAR: begin
                we_d    = 1'b1;
                wreg_d  = idx_q;
                wdata_d = '0;
                // Stop at the last index so the counter never wraps to r0.
                if (idx_q == IDX_LAST) begin
                    busy_d = 1'b0;
                    idx_d  = IDX_FIRST;
                end else begin
                    idx_d = idx_q + IDX_FIRST;
                end
            end
            default: ;
        endcase
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign clear_busy   = busy_q;
    assign rf_writeEn   = we_q;
    assign rf_writeReg  = wreg_q;
    assign rf_writeData = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: behavioural model predicts grants and the
// per-edge regfile write; a monitor pops and compares the registered outputs.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock;
    logic          rst;
    logic          v0, v1, clr;
    logic [AW-1:0] r0, r1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rdy1, busy, wen;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR)
    ) dut (
        .clock       (clock),
        .ctrl_reset  (rst),
        .req0_valid  (v0),
        .req0_reg    (r0),
        .req0_data   (d0),
        .req0_ready  (rdy0),
        .req1_valid  (v1),
        .req1_reg    (r1),
        .req1_data   (d1),
        .req1_ready  (rdy1),
        .clear_start (clr),
        .clear_busy  (busy),
        .rf_writeEn  (wen),
        .rf_writeReg (wreg),
        .rf_writeData(wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit            en;
        bit            chk;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mrf[NR];
    logic [DW-1:0] dut_rf[NR];
    int            n_checks = 0;
    int            n_fail   = 0;

    int  favour     = 0;
    int  clear_left = 0;
    int  clear_next = 1;
    bit  exp_busy   = 0;
    bit  started    = 0;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_en", {31'b0, wen}, {31'b0, e.en});
                if (e.chk) begin
                    chk("wr_reg", {27'b0, wreg}, {27'b0, e.r});
                    chk("wr_data", wdata, e.d);
                end
            end
            if (wen === 1'b1) dut_rf[wreg] = wdata;
        end
    end

    // One clock: check readies, advance the model across the edge.
    task automatic step();
        exp_t e;
        bit g0, g1;
        logic [AW-1:0] rr;
        logic [DW-1:0] dd;
        @(negedge clock);
        if (started) chk("clear_busy", {31'b0, busy}, {31'b0, exp_busy});
        g0 = 0;
        g1 = 0;
        if (rst && clear_left == 0 && !clr) begin
            if (v0 && v1) begin
                g0 = (favour == 0);
                g1 = (favour == 1);
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("req0_ready", {31'b0, rdy0}, {31'b0, g0});
        chk("req1_ready", {31'b0, rdy1}, {31'b0, g1});
        if (g0 && g1) chk("one_hot_model", 1, 0);
        e.en = 0;
        e.chk = 0;
        e.r = '0;
        e.d = '0;
        if (!rst) begin
            favour = 0;
            clear_left = 0;
            clear_next = 1;
            e.chk = 1;
            started = 1;
        end else if (clear_left > 0) begin
            e.en = 1;
            e.chk = 1;
            e.r = AW'(clear_next);
            mrf[clear_next] = '0;
            clear_next++;
            clear_left--;
        end else if (clr) begin
            clear_left = NR - 1;
            clear_next = 1;
        end else if (g0 || g1) begin
            rr = g0 ? r0 : r1;
            dd = g0 ? d0 : d1;
            e.chk = 1;
            e.r = rr;
            e.d = dd;
            e.en = (rr != 0);
            if (rr != 0) mrf[rr] = dd;
            favour = g0 ? 1 : 0;
        end
        exp_q.push_back(e);
        exp_busy = (clear_left > 0);
        @(posedge clock);
        #1;
        clr = 0;
        if (g0) v0 = 0;
        if (g1) v1 = 0;
    endtask

    task automatic send(int who, int rg, logic [DW-1:0] dat);
        if (who == 0) begin
            v0 = 1; r0 = AW'(rg); d0 = dat;
        end else begin
            v1 = 1; r1 = AW'(rg); d1 = dat;
        end
        for (int i = 0; i < 8 && (who == 0 ? v0 : v1); i++) step();
        chk("send_timeout", {31'b0, (who == 0 ? v0 : v1)}, 0);
    endtask

    task automatic cmp_rf();
        #2;
        for (int i = 0; i < NR; i++) chk($sformatf("rf[%0d]", i), dut_rf[i], mrf[i]);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            mrf[i] = '0;
            dut_rf[i] = '0;
        end
        rst = 0; clr = 0;
        v0 = 0; v1 = 0; r0 = '0; r1 = '0; d0 = '0; d1 = '0;
        step();
        step();
        rst = 1;
        step();
        step();

        send(0, 5, 32'h0000_00A5);
        step();
        send(1, 0, 32'hDEAD_BEEF);
        step();

        // Both requesters busy: expect alternating grants 2,3,2,3.
        for (int i = 0; i < 4; i++) begin
            if (!v0) begin v0 = 1; r0 = 5'd2; d0 = 32'h200 + i; end
            if (!v1) begin v1 = 1; r1 = 5'd3; d1 = 32'h300 + i; end
            step();
        end
        for (int i = 0; i < 4 && (v0 || v1); i++) step();

        for (int k = 1; k < NR; k++) send(k % 2, k, DW'(k));
        cmp_rf();

        // Clear with a pending req0: clear wins, req0 served afterwards.
        v0 = 1; r0 = 5'd7; d0 = 32'h77; clr = 1;
        for (int i = 0; i < 40 && v0; i++) step();
        chk("post_clear_grant", {31'b0, v0}, 0);
        step();
        cmp_rf();

        // Reset aborts a clear after r10 is written.
        for (int k = 1; k < NR; k++) send(k % 2, k, DW'(k));
        clr = 1;
        step();
        repeat (10) step();
        rst = 0;
        step();
        rst = 1;
        step();
        cmp_rf();

        // Randomized traffic with occasional clears and resets.
        for (int c = 0; c < 600; c++) begin
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1; r0 = AW'($urandom_range(0, NR - 1)); d0 = $urandom;
            end
            if (!v1 && $urandom_range(0, 2) != 0) begin
                v1 = 1; r1 = AW'($urandom_range(0, NR - 1)); d1 = $urandom;
            end
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 149) != 0);
            step();
            rst = 1;
        end

        v0 = 0; v1 = 0; clr = 0;
        for (int i = 0; i < 40 && exp_busy; i++) step();
        step();
        step();
        cmp_rf();
        chk("queue_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the single write port of the 32x32 register file and shares it between two writeback requesters: req0 (ALU writeback) and req1 (memory/load writeback). Requesters are served round-robin with a valid/ready handshake. Writes to register 0 are silently dropped. A built-in clear sequencer zeroes registers 1..NUM_REGS-1 on command. Outputs connect directly to the regfile ctrl_writeEn, ctrl_writeReg and data_writeReg inputs.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, width of register index
NUM_REGS, 32, number of registers; clear walks indices 1..NUM_REGS-1

Ports:
clock  in  1  single clock; all state updates on its rising edge
ctrl_reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
req0_valid  in  1  requester 0 has a write pending
req0_reg  in  ADDR_WIDTH  requester 0 destination register
req0_data  in  DATA_WIDTH  requester 0 write data
req0_ready  out  1  requester 0 transfer accepted this cycle (combinational)
req1_valid  in  1  requester 1 has a write pending
req1_reg  in  ADDR_WIDTH  requester 1 destination register
req1_data  in  DATA_WIDTH  requester 1 write data
req1_ready  out  1  requester 1 transfer accepted this cycle (combinational)
clear_start  in  1  one-cycle pulse requesting a register clear
clear_busy  out  1  clear sequence in progress (registered)
rf_writeEn  out  1  to regfile ctrl_writeEn (registered)
rf_writeReg  out  ADDR_WIDTH  to regfile ctrl_writeReg (registered)
rf_writeData  out  DATA_WIDTH  to regfile data_writeReg (registered)

Behaviour:
- Reset (ctrl_reset==0 at a rising edge): state=IDLE; prio=0 (req0 favoured); clear index=1; rf_writeEn=0; rf_writeReg=0; rf_writeData=0; clear_busy=0. Both ready outputs are 0 while ctrl_reset==0.
- FSM states: IDLE and CLEAR.
- IDLE arbitration (combinational):
  - If clear_start=1, both ready outputs are 0.
  - Otherwise, if only one requester is valid, that requester gets ready=1.
  - If both are valid, the requester selected by prio gets ready=1 and the other gets 0.
  - At most one ready is high in any cycle.
- Transfer: occurs when valid&&ready at a rising edge.
  - At that edge: rf_writeReg<=reg, rf_writeData<=data, rf_writeEn<=(reg!=0). Latency is 1 cycle and throughput is 1 write per cycle.
  - prio<=index of the requester not granted.
  - A write to register 0 still completes the handshake but produces rf_writeEn=0.
- No transfer in a cycle: rf_writeEn<=0. rf_writeReg and rf_writeData hold their previous values.
- Requesters must hold valid, reg and data stable until the transfer completes. No request is ever lost or duplicated.
- IDLE with clear_start=1 at an edge: state<=CLEAR, index<=1, clear_busy<=1. No requester transfer occurs in that cycle; clear beats requests.
- CLEAR state, each edge:
  - rf_writeEn<=1, rf_writeReg<=index, rf_writeData<=0, index<=index+1.
  - When index==NUM_REGS-1: state<=IDLE, clear_busy<=0, index<=1.
  - Result: clear_busy is high for exactly NUM_REGS-1 cycles. rf_writeEn is high for NUM_REGS-1 consecutive cycles, starting one cycle after clear_busy rises.
- In CLEAR, both ready outputs are 0 and clear_start is ignored.
- Reset during CLEAR aborts the sequence. Registers not yet written are left untouched.
- The index counter is ADDR_WIDTH bits wide. The compare against NUM_REGS-1 prevents wrap-around to 0.

Test Plan:
- Reset held 2 cycles, then released with no requests -> all outputs 0, both ready=0, rf_writeEn=0.
- req0 valid (reg 5, data 0x0000_00A5) alone -> req0_ready=1 the same cycle; next cycle rf_writeEn=1, rf_writeReg=5, rf_writeData=0x000000A5; the regfile then reads 0x000000A5 on port A.
- req0 and req1 held valid for 4 cycles (regs 2 and 3) -> grants in order req0, req1, req0, req1; no cycle has both ready high; rf_writeReg sequence is 2, 3, 2, 3.
- req1 write to reg 0 (data 0xDEAD_BEEF) -> req1_ready=1, rf_writeEn stays 0; regfile reg 0 reads 0.
- After writing reg k = k for k = 1..31, pulse clear_start with req0 valid in the same cycle -> req0_ready=0; clear_busy high for 31 cycles; regs 1..31 written 0 in order; afterwards req0 is granted and every register reads 0 except the pending req0 write.
- ctrl_reset asserted mid-clear after reg 10 is written -> rf_writeEn=0 the next cycle and clear_busy=0; regs 11..31 keep their old values.
